// File: rtl/lock_pkg.sv
// Shared constants for the 4-key lock keypad: key count, conditioner FSM
// encoding and the default debounce length.
package lock_pkg;

    localparam int NUM_KEYS            = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    localparam logic [1:0] COND_IDLE = 2'd0;
    localparam logic [1:0] COND_HELD = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = COND_IDLE,
        ST_HELD = COND_HELD
    } cond_state_e;

    typedef logic [NUM_KEYS-1:0] key_vec_t;

endpackage

// File: rtl/key_pulse_conditioner_if.sv
// Keypad-side signal bundle: raw key levels in, press pulses and held flag out.
interface key_pulse_conditioner_if;
    import lock_pkg::*;

    key_vec_t keys_raw;
    key_vec_t keys;
    logic     held;

    modport master (output keys_raw, input keys, input held);
    modport slave  (input keys_raw, output keys, output held);
endinterface

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer followed by a symmetric press/release debouncer.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = lock_pkg::DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // A disagreement run must last DEBOUNCE_CYCLES edges before the level flips.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/key_pulse_conditioner.sv
// Debounced keypad front end: one single-cycle pulse per press, with a
// roll-over lockout that drops further presses until every key is released.
module key_pulse_conditioner
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    key_pulse_conditioner_if.slave  kp
);
    key_vec_t    stable;
    key_vec_t    stable_dly_q, stable_dly_d;
    key_vec_t    rise;
    key_vec_t    keys_q, keys_d;
    cond_state_e state_q, state_d;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .raw    (kp.keys_raw[i]),
            .stable (stable[i])
        );
    end

    always_comb begin
        stable_dly_d = stable;
        rise         = stable & ~stable_dly_q;
        keys_d       = '0;
        state_d      = state_q;
        case (state_q)
            // All keys rising together are emitted as one multi-bit pulse.
            ST_IDLE: begin
                if (rise != '0) begin
                    keys_d  = rise;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (stable == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_dly_q <= '0;
            keys_q       <= '0;
            state_q      <= ST_IDLE;
        end else begin
            stable_dly_q <= stable_dly_d;
            keys_q       <= keys_d;
            state_q      <= state_d;
        end
    end

    assign kp.keys = keys_q;
    assign kp.held = |stable;

endmodule
